// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, fetches over req/ack, strobes opcodes
// to the control unit and retires instructions on ALU completion or jump.
module instr_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [2:0]         opcode,
  output logic               opcode_valid,
  input  logic               alu_done,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  localparam logic [2:0] OP_JUMP = 3'b100;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [CNT_W-1:0]   retired_q;
  logic               stop_pend;
  logic               is_jump, illegal, exec_done;

  assign opcode    = instr_q[INSTR_W-1 -: 3];
  assign is_jump   = (opcode == OP_JUMP);
  assign illegal   = (opcode > OP_JUMP);
  assign exec_done = (state == S_EXEC) && (is_jump || alu_done);

  // Bits between the opcode and the jump target carry nothing for this sequencer.
  logic unused_mid;
  assign unused_mid = ^instr_q[INSTR_W-4:ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = illegal ? S_HALT : S_EXEC;
      S_EXEC:   if (exec_done) state_nxt = (stop_pend || stop) ? S_IDLE : S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req     = (state == S_FETCH);
    opcode_valid = (state == S_DECODE) && !illegal;
    busy         = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    halted       = (state == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
      stop_pend <= 1'b0;
    end else begin
      if (state == S_IDLE && start)
        pc_q <= '0;
      else if (exec_done)
        pc_q <= is_jump ? instr_q[ADDR_W-1:0] : pc_q + 1'b1;

      if (state == S_FETCH && imem_ack)
        instr_q <= imem_rdata;

      if (exec_done && retired_q != '1)
        retired_q <= retired_q + 1'b1;

      // A stop landing on the completion cycle is consumed by the IDLE transition itself.
      if (exec_done)
        stop_pend <= 1'b0;
      else if (busy && stop)
        stop_pend <= 1'b1;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: memory/ALU responders plus cycle-exact checks.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_rdata;
  logic [2:0]  opcode;
  logic        opcode_valid, alu_done, busy, halted;
  logic [15:0] retired;

  logic [15:0] mem [256];
  int          ack_dly = 0;
  int          wcnt = 0;
  logic        alu_auto = 1'b1, alu_man = 1'b0, ov_q = 1'b0;
  int          n_cmp = 0, n_err = 0;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opcode(opcode), .opcode_valid(opcode_valid), .alu_done(alu_done),
    .pc(pc), .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  // Memory answers after ack_dly waiting cycles; ALU finishes one cycle after a non-jump strobe.
  assign imem_ack   = imem_req && (wcnt >= ack_dly);
  assign imem_rdata = mem[imem_addr];
  always @(posedge clk) wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;
  always @(posedge clk) ov_q <= opcode_valid && (opcode != 3'b100);
  assign alu_done = alu_auto ? ov_q : alu_man;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    alu_auto = 1'b1; alu_man = 1'b0; ack_dly = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    tick; tick;
    rst = 1'b1;
  endtask

  task automatic kick;
    start = 1'b1; tick; start = 1'b0;
  endtask

  function automatic logic [15:0] ins(input logic [2:0] op, input logic [7:0] tgt);
    return {op, 5'b0, tgt};
  endfunction

  initial begin
    // Reset state
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_ov", opcode_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    chk("rst_opcode", opcode, 0);

    // ADD, SUB with stop during the second fetch
    do_reset;
    mem[0] = ins(3'b000, 8'h00); mem[1] = ins(3'b001, 8'h00);
    tick;
    kick;
    chk("t2_c0_req", imem_req, 1);
    chk("t2_c0_addr", imem_addr, 0);
    tick;
    chk("t2_c1_ov", opcode_valid, 1);
    chk("t2_c1_op", opcode, 3'b000);
    chk("t2_c1_req", imem_req, 0);
    tick;
    chk("t2_c2_ov", opcode_valid, 0);
    chk("t2_c2_pc", pc, 0);
    tick;
    chk("t2_c3_req", imem_req, 1);
    chk("t2_c3_pc", pc, 1);
    chk("t2_c3_ret", retired, 1);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("t2_c4_ov", opcode_valid, 1);
    chk("t2_c4_op", opcode, 3'b001);
    tick;
    chk("t2_c5_busy", busy, 1);
    tick;
    chk("t2_c6_busy", busy, 0);
    chk("t2_c6_pc", pc, 2);
    chk("t2_c6_ret", retired, 2);
    chk("t2_c6_req", imem_req, 0);

    // JUMP to 0x20, then async reset in the middle of the next fetch
    do_reset;
    mem[0] = ins(3'b100, 8'h20);
    kick;
    tick;
    chk("t3_ov", opcode_valid, 1);
    chk("t3_op", opcode, 3'b100);
    tick;
    ack_dly = 10;
    tick;
    chk("t3_addr", imem_addr, 8'h20);
    chk("t3_req", imem_req, 1);
    chk("t3_ret", retired, 1);
    rst = 1'b0;
    #1;
    chk("t1_async_req", imem_req, 0);
    chk("t1_async_pc", pc, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_ret", retired, 0);
    tick;
    rst = 1'b1;

    // PC wrap: JUMP 0xFF, OR at 0xFF
    do_reset;
    mem[0] = ins(3'b100, 8'hFF); mem[8'hFF] = ins(3'b011, 8'h00);
    kick;
    tick; tick; tick;
    chk("t4_addr_ff", imem_addr, 8'hFF);
    tick;
    chk("t4_op", opcode, 3'b011);
    tick; tick;
    chk("t4_wrap_addr", imem_addr, 8'h00);
    chk("t4_wrap_req", imem_req, 1);
    chk("t4_ret", retired, 2);

    // Illegal opcode 110 at pc=3
    do_reset;
    mem[0] = ins(3'b100, 8'h03); mem[3] = ins(3'b110, 8'h00);
    kick;
    tick; tick; tick;
    chk("t5_pc", pc, 3);
    tick;
    chk("t5_dec_ov", opcode_valid, 0);
    tick;
    chk("t5_halted", halted, 1);
    chk("t5_busy", busy, 0);
    chk("t5_ov", opcode_valid, 0);
    chk("t5_pc_frz", pc, 3);
    chk("t5_ret_frz", retired, 1);
    kick;
    tick;
    chk("t5_start_halted", halted, 1);
    chk("t5_start_req", imem_req, 0);
    rst = 1'b0;
    #1;
    chk("t5_rst_halted", halted, 0);
    tick;
    rst = 1'b1;
    tick;
    chk("t5_idle_busy", busy, 0);

    // Stop while waiting for alu_done at pc=5, with 4-cycle ack delay
    do_reset;
    mem[0] = ins(3'b100, 8'h05); mem[5] = ins(3'b000, 8'h00);
    ack_dly = 4; alu_auto = 1'b0;
    kick;
    for (int i = 0; i < 5; i++) begin
      chk("t6_f0_req", imem_req, 1);
      chk("t6_f0_addr", imem_addr, 0);
      tick;
    end
    chk("t6_dec0_ov", opcode_valid, 1);
    tick; tick;
    for (int i = 0; i < 5; i++) begin
      chk("t6_f5_req", imem_req, 1);
      chk("t6_f5_addr", imem_addr, 5);
      tick;
    end
    chk("t6_dec5_ov", opcode_valid, 1);
    chk("t6_dec5_op", opcode, 3'b000);
    tick;
    stop = 1'b1;
    chk("t6_exec_busy", busy, 1);
    tick;
    stop = 1'b0;
    chk("t6_wait_pc", pc, 5);
    chk("t6_wait_busy", busy, 1);
    tick;
    alu_man = 1'b1;
    tick;
    alu_man = 1'b0;
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_pc", pc, 6);
    chk("t6_idle_req", imem_req, 0);
    chk("t6_idle_ret", retired, 2);
    tick;
    chk("t6_idle_req2", imem_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
